// File: rtl/alu_uart_pkg.sv
// ---------------------------------------------------------------------------
// alu_uart_pkg
// Shared definitions for the ALU/UART sequencing controller: the 3-bit state
// encoding, the FSM state type and the ALU operation codes understood by the
// ALU that sits beside the controller at the top level.
// ---------------------------------------------------------------------------
package alu_uart_pkg;

  // State encoding
  localparam logic [2:0] S_GET_A   = 3'd0;
  localparam logic [2:0] S_GET_B   = 3'd1;
  localparam logic [2:0] S_GET_OP  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    GET_A   = S_GET_A,
    GET_B   = S_GET_B,
    GET_OP  = S_GET_OP,
    EXEC    = S_EXEC,
    SEND    = S_SEND,
    WAIT_TX = S_WAIT_TX
  } state_t;

  // ALU operation codes
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  // States in which a result is being produced or shipped out; a received
  // byte arriving here has nowhere to go.
  function automatic logic is_busy_state(input state_t s);
    return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl_if
// Bundles the controller's connections to the UART RX, the ALU and the UART TX.
//   i_rx_data / i_rx_done   : received byte and its 1-cycle valid pulse
//   i_alu_result            : combinational ALU output
//   i_tx_done               : 1-cycle pulse when TX has finished a byte
//   o_data_a / o_data_b     : signed operands to the ALU
//   o_operation             : ALU op code
//   o_tx_data / o_tx_start  : byte to transmit and its 1-cycle start pulse
//   o_busy                  : result being computed or sent
//   o_rx_overrun            : sticky, a received byte was dropped
// master = controller side, slave = surrounding RX/ALU/TX side.
// ---------------------------------------------------------------------------
interface alu_uart_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);

  logic        [NB_DATA-1:0] i_rx_data;
  logic                      i_rx_done;
  logic        [NB_DATA-1:0] i_alu_result;
  logic                      i_tx_done;
  logic signed [NB_DATA-1:0] o_data_a;
  logic signed [NB_DATA-1:0] o_data_b;
  logic        [NB_OP-1:0]   o_operation;
  logic        [NB_DATA-1:0] o_tx_data;
  logic                      o_tx_start;
  logic                      o_busy;
  logic                      o_rx_overrun;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_operation, o_tx_data,
           o_tx_start, o_busy, o_rx_overrun
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_operation, o_tx_data,
           o_tx_start, o_busy, o_rx_overrun
  );

endinterface

// File: rtl/alu_uart_ctrl.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl
// Collects three UART bytes (operand A, operand B, op code), lets the external
// ALU settle for one cycle, captures its result and hands it to the UART TX,
// then waits for TX completion before accepting the next operand A.
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : synchronous, active-high
//   bus     : alu_uart_ctrl_if.master (RX, ALU and TX connections)
//
// state   | meaning
// --------+-------------------------------------------------------------
// GET_A   | waiting for operand A byte
// GET_B   | waiting for operand B byte
// GET_OP  | waiting for op-code byte
// EXEC    | one cycle for the ALU to settle; result captured at its end
// SEND    | one cycle, o_tx_start high
// WAIT_TX | holding until the TX reports the byte is out
// ---------------------------------------------------------------------------
module alu_uart_ctrl
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  alu_uart_ctrl_if.master   bus
);

  state_t                    state_q;
  state_t                    state_d;

  logic signed [NB_DATA-1:0] data_a_q;
  logic signed [NB_DATA-1:0] data_b_q;
  logic        [NB_OP-1:0]   operation_q;
  logic        [NB_DATA-1:0] tx_data_q;
  logic                      rx_overrun_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= GET_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:   if (bus.i_rx_done) state_d = GET_B;
      GET_B:   if (bus.i_rx_done) state_d = GET_OP;
      GET_OP:  if (bus.i_rx_done) state_d = EXEC;
      EXEC:    state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (bus.i_tx_done) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  // Datapath registers. A byte arriving while busy is dropped, operands are
  // left intact and the overrun flag latches until reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_a_q     <= '0;
      data_b_q     <= '0;
      operation_q  <= '0;
      tx_data_q    <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (bus.i_rx_done) begin
        case (state_q)
          GET_A:   data_a_q    <= bus.i_rx_data;
          GET_B:   data_b_q    <= bus.i_rx_data;
          GET_OP:  operation_q <= bus.i_rx_data[NB_OP-1:0];
          EXEC, SEND, WAIT_TX: rx_overrun_q <= 1'b1;
          default: ;
        endcase
      end
      if (state_q == EXEC) begin
        tx_data_q <= bus.i_alu_result;
      end
    end
  end

  assign bus.o_data_a     = data_a_q;
  assign bus.o_data_b     = data_b_q;
  assign bus.o_operation  = operation_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_rx_overrun = rx_overrun_q;
  assign bus.o_tx_start   = (state_q == SEND);
  assign bus.o_busy       = is_busy_state(state_q);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
module tb_alu_uart_ctrl;
  import alu_uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  // Expected view of the controller, maintained from the bytes the bench sends
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  logic       m_ovr;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return sa >>> b;
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // Environment ALU fed from the controller's operand outputs
  assign bus.i_alu_result = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_operation);

  always @(negedge clk) if (bus.o_tx_start === 1'b1) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_ovr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (bus.o_data_a !== 8'h00 || bus.o_data_b !== 8'h00 || bus.o_operation !== 6'h00 ||
        bus.o_tx_data !== 8'h00 || bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_rx_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got a=%h b=%h op=%h tx=%h start=%b busy=%b ovr=%b want all zero",
               tag, bus.o_data_a, bus.o_data_b, bus.o_operation, bus.o_tx_data,
               bus.o_tx_start, bus.o_busy, bus.o_rx_overrun);
    end
  endtask

  // Operand bytes, with optional idle gaps carrying stray tx_done pulses
  task automatic send_operands(input logic [7:0] a, input logic [7:0] b, input bit gaps);
    int n;
    send_byte(a);
    m_a = a;
    vectors++;
    if (bus.o_data_a !== m_a || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL operand_a: got a=%h busy=%b want a=%h busy=0", bus.o_data_a, bus.o_busy, m_a);
    end
    if (gaps) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) pulse_tx_done(); else tick();
      end
    end
    send_byte(b);
    m_b = b;
    vectors++;
    if (bus.o_data_b !== m_b || bus.o_data_a !== m_a) begin
      miscompares++;
      $display("FAIL operand_b: got a=%h b=%h want a=%h b=%h", bus.o_data_a, bus.o_data_b, m_a, m_b);
    end
  endtask

  // Op byte through to TX completion; optional dropped byte during WAIT_TX
  task automatic send_op_complete(input logic [7:0] opb, input bit extra,
                                  input logic [7:0] extra_byte, input int delay);
    int s0;
    s0 = start_cnt;
    send_byte(opb);
    m_op = opb[5:0];
    m_tx = alu_ref(m_a, m_b, m_op);
    vectors++;
    if (bus.o_operation !== m_op || bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL exec_cycle: got op=%h busy=%b start=%b want op=%h busy=1 start=0",
               bus.o_operation, bus.o_busy, bus.o_tx_start, m_op);
    end
    tick();
    vectors++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== m_tx) begin
      miscompares++;
      $display("FAIL send_cycle: got start=%b tx=%h want start=1 tx=%h",
               bus.o_tx_start, bus.o_tx_data, m_tx);
    end
    tick();
    vectors++;
    if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_tx_entry: got start=%b busy=%b want start=0 busy=1",
               bus.o_tx_start, bus.o_busy);
    end
    if (extra) begin
      send_byte(extra_byte);
      m_ovr = 1'b1;
      vectors++;
      if (bus.o_data_a !== m_a || bus.o_data_b !== m_b || bus.o_operation !== m_op ||
          bus.o_rx_overrun !== 1'b1) begin
        miscompares++;
        $display("FAIL dropped_byte: got a=%h b=%h op=%h ovr=%b want a=%h b=%h op=%h ovr=1",
                 bus.o_data_a, bus.o_data_b, bus.o_operation, bus.o_rx_overrun, m_a, m_b, m_op);
      end
    end
    repeat (delay) tick();
    vectors++;
    if (bus.o_busy !== 1'b1 || bus.o_tx_data !== m_tx || bus.o_rx_overrun !== m_ovr) begin
      miscompares++;
      $display("FAIL wait_tx_hold: got busy=%b tx=%h ovr=%b want busy=1 tx=%h ovr=%b",
               bus.o_busy, bus.o_tx_data, bus.o_rx_overrun, m_tx, m_ovr);
    end
    pulse_tx_done();
    vectors++;
    if (bus.o_busy !== 1'b0 || (start_cnt - s0) != 1 || bus.o_tx_data !== m_tx) begin
      miscompares++;
      $display("FAIL tx_complete: got busy=%b starts=%0d tx=%h want busy=0 starts=1 tx=%h",
               bus.o_busy, start_cnt - s0, bus.o_tx_data, m_tx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_ovr = 0;
  endtask

  task automatic test_basic();
    send_operands(8'h05, 8'h03, 1'b0);
    send_op_complete(8'h20, 1'b0, 8'h00, 2);
    vectors++;
    if (bus.o_tx_data !== 8'h08) begin
      miscompares++;
      $display("FAIL basic_result: got %h want 08", bus.o_tx_data);
    end
  endtask

  task automatic test_op_mask();
    send_operands(8'($urandom), 8'($urandom), 1'b0);
    send_op_complete(8'hE2, 1'b0, 8'h00, 1);
    vectors++;
    if (bus.o_operation !== 6'h22) begin
      miscompares++;
      $display("FAIL op_mask: got %h want 22", bus.o_operation);
    end
  endtask

  task automatic test_overrun();
    send_operands(8'h40, 8'h0F, 1'b0);
    send_op_complete(8'h24, 1'b1, 8'h55, 2);
    send_byte(8'h07);
    m_a = 8'h07;
    vectors++;
    if (bus.o_data_a !== 8'h07 || bus.o_rx_overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_next_a: got a=%h ovr=%b want a=07 ovr=1", bus.o_data_a, bus.o_rx_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    // Overrun is set from the previous scenario and the FSM sits in GET_B
    do_reset();
    check_all_zero("reset_clears_overrun");
    send_byte(8'h11);
    send_byte(8'h22);
    s0 = start_cnt;
    do_reset();
    check_all_zero("reset_mid_sequence");
    repeat (8) tick();
    vectors++;
    if (start_cnt != s0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_start: got starts=%0d busy=%b want starts=0 busy=0", start_cnt - s0, bus.o_busy);
    end
    // Reset landing in EXEC: the pending result must never start
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    s0 = start_cnt;
    rst = 1'b1;
    bus.i_rx_data = 8'hAA; bus.i_rx_done = 1'b1; bus.i_tx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_ovr = 0;
    check_all_zero("reset_in_exec");
    repeat (6) tick();
    vectors++;
    if (start_cnt != s0) begin
      miscompares++;
      $display("FAIL reset_exec_no_start: got starts=%0d want 0", start_cnt - s0);
    end
    // Back in GET_A: a full transaction goes through normally
    send_operands(8'h09, 8'h04, 1'b0);
    send_op_complete(8'h22, 1'b0, 8'h00, 0);
  endtask

  task automatic test_simultaneous();
    send_operands(8'h33, 8'h44, 1'b0);
    send_byte(8'h25);
    m_op = 6'h25;
    tick();
    tick();
    bus.i_rx_data = 8'h99; bus.i_rx_done = 1'b1; bus.i_tx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    m_ovr = 1'b1;
    vectors++;
    if (bus.o_busy !== 1'b0 || bus.o_rx_overrun !== 1'b1 || bus.o_data_a !== m_a ||
        bus.o_data_b !== m_b) begin
      miscompares++;
      $display("FAIL simultaneous: got busy=%b ovr=%b a=%h b=%h want busy=0 ovr=1 a=%h b=%h",
               bus.o_busy, bus.o_rx_overrun, bus.o_data_a, bus.o_data_b, m_a, m_b);
    end
    send_byte(8'h3C);
    m_a = 8'h3C;
    vectors++;
    if (bus.o_data_a !== 8'h3C) begin
      miscompares++;
      $display("FAIL simultaneous_next_a: got %h want 3c", bus.o_data_a);
    end
  endtask

  // Continues from GET_B left by the previous scenario
  task automatic test_tx_done_get_b();
    logic [7:0] a0, b0, tx0;
    logic [5:0] op0;
    a0 = bus.o_data_a; b0 = bus.o_data_b; op0 = bus.o_operation; tx0 = bus.o_tx_data;
    pulse_tx_done();
    tick();
    vectors++;
    if (bus.o_data_a !== m_a || bus.o_data_b !== b0 || bus.o_operation !== op0 ||
        bus.o_tx_data !== tx0 || bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_done_in_get_b: outputs changed a=%h b=%h op=%h tx=%h busy=%b start=%b",
               bus.o_data_a, bus.o_data_b, bus.o_operation, bus.o_tx_data, bus.o_busy, bus.o_tx_start);
    end
    send_byte(8'h0B);
    m_b = 8'h0B;
    vectors++;
    if (bus.o_data_b !== 8'h0B || bus.o_data_a !== m_a) begin
      miscompares++;
      $display("FAIL get_b_after_tx_done: got a=%h b=%h want a=%h b=0b", bus.o_data_a, bus.o_data_b, m_a);
    end
    send_op_complete(8'h26, 1'b0, 8'h00, 1);
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [7:0] opb;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) opb = 8'($urandom);
      else opb = {2'($urandom), ops[$urandom_range(0, 7)]};
      send_operands(8'($urandom), 8'($urandom), 1'b1);
      send_op_complete(opb, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 5));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    test_reset();
    test_basic();
    test_op_mask();
    test_overrun();
    test_reset_mid();
    test_simultaneous();
    test_tx_done_get_b();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
